// File: rtl/swd_host_pkg.sv
// swd_host shared types: FSM states, ACK codes, bit counts
// and the request/parity helpers.
package swd_host_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LRST,
        S_REQ,
        S_TRN1,
        S_ACK,
        S_RDATA,
        S_TRN2,
        S_WDATA,
        S_TAIL
    } state_e;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    localparam int LRST_BITS = 56;
    localparam int REQ_BITS  = 8;

    function automatic logic parity(input logic [31:0] d);
        return ^d;
    endfunction

    // LSB first on the wire: start, APnDP, RnW, A2, A3, par, stop, park
    function automatic logic [7:0] req_byte(
        input logic       apndp,
        input logic       rnw,
        input logic [1:0] addr
    );
        logic p;
        p = apndp ^ rnw ^ addr[0] ^ addr[1];
        return {1'b1, 1'b0, p, addr[1], addr[0], rnw, apndp, 1'b1};
    endfunction

endpackage

// File: rtl/swd_host_if.sv
// swd_host parallel request/response port bundle.
// master = requester side, slave = swd_host side.
interface swd_host_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_lrst;
    logic        req_apndp;
    logic        req_rnw;
    logic [1:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;
    logic        rsp_perr;

    modport master (
        output req_valid, req_lrst, req_apndp, req_rnw,
        output req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr
    );

    modport slave (
        input  req_valid, req_lrst, req_apndp, req_rnw,
        input  req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr
    );
endinterface

// File: rtl/swd_host_bit_timer.sv
// SWD bit-cell timer: CLK_DIV low cycles then CLK_DIV high cycles,
// with launch, sample and end-of-cell strobes.
module swd_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic start_i,
    output logic swclk_o,
    output logic drive_stb_o,
    output logic sample_stb_o,
    output logic cell_end_o
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          high_q, high_d;
    logic          last;

    assign last = (cnt_q == LAST);

    always_comb begin
        cnt_d  = cnt_q;
        high_d = high_q;
        if (!run_i) begin
            cnt_d  = '0;
            high_d = 1'b0;
        end else if (last) begin
            cnt_d  = '0;
            high_d = ~high_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            high_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            high_q <= high_d;
        end
    end

    assign swclk_o      = high_q;
    assign sample_stb_o = run_i & ~high_q & last;
    assign cell_end_o   = run_i & high_q & last;
    // registered outputs loaded here appear in the next low phase
    assign drive_stb_o  = start_i | cell_end_o;

endmodule

// File: rtl/swd_host.sv
// SWD host: runs one DP/AP transaction or a line reset per request
// over SWCLK/SWDIO, reporting ACK, read data and parity status.
module swd_host
    import swd_host_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int IDLE_BITS = 8
) (
    input  logic       CLKIN,
    input  logic       nSRSTIN,
    swd_host_if.slave  bus,
    output logic       SWCLK,
    output logic       SWDIO_o,
    output logic       SWDIO_oe,
    input  logic       SWDIO_i
);
    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] sr_q, sr_d;
    logic [2:0]  ack_q, ack_d, ack_in;
    logic        rdok_q, rdok_d;
    logic        rnw_q;
    logic [31:0] wdata_q;
    logic        dout_q, dout_d, oe_q, oe_d;
    logic        din_q;
    logic        rsp_valid_q, rsp_perr_q;
    logic [2:0]  rsp_ack_q;
    logic [31:0] rsp_rdata_q;
    logic        accept, run, to_tail, done;
    logic        drive_stb, sample_stb, cell_end;

    assign accept = bus.req_valid & (state_q == S_IDLE);
    assign run    = (state_q != S_IDLE);
    assign ack_in = {din_q, ack_q[2:1]};

    swd_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk_i        (CLKIN),
        .rst_ni       (nSRSTIN),
        .run_i        (run),
        .start_i      (accept),
        .swclk_o      (SWCLK),
        .drive_stb_o  (drive_stb),
        .sample_stb_o (sample_stb),
        .cell_end_o   (cell_end)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        ack_d   = ack_q;
        rdok_d  = rdok_q;
        to_tail = 1'b0;
        done    = 1'b0;
        if (run && cell_end) cnt_d = cnt_q + 6'd1;
        unique case (state_q)
            S_IDLE: if (bus.req_valid) begin
                cnt_d  = '0;
                rdok_d = 1'b0;
                if (bus.req_lrst) begin
                    state_d = S_LRST;
                    ack_d   = ACK_OK;
                end else begin
                    state_d = S_REQ;
                    sr_d    = {25'b0, req_byte(bus.req_apndp,
                                bus.req_rnw, bus.req_addr)};
                end
            end
            S_LRST: if (cell_end && cnt_q == 6'(LRST_BITS - 1))
                to_tail = 1'b1;
            S_REQ: if (cell_end) begin
                sr_d = {1'b0, sr_q[32:1]};
                if (cnt_q == 6'(REQ_BITS - 1)) begin
                    state_d = S_TRN1;
                    cnt_d   = '0;
                end
            end
            S_TRN1: if (cell_end) begin
                state_d = S_ACK;
                cnt_d   = '0;
            end
            S_ACK: if (cell_end) begin
                ack_d = ack_in;
                if (cnt_q == 6'd2) begin
                    cnt_d   = '0;
                    state_d = (ack_in == ACK_OK && rnw_q) ? S_RDATA
                                                          : S_TRN2;
                end
            end
            S_RDATA: if (cell_end) begin
                sr_d = {din_q, sr_q[32:1]};
                if (cnt_q == 6'd32) begin
                    state_d = S_TRN2;
                    cnt_d   = '0;
                    rdok_d  = 1'b1;
                end
            end
            S_TRN2: if (cell_end) begin
                cnt_d = '0;
                if (ack_q == ACK_OK && !rnw_q) begin
                    state_d = S_WDATA;
                    sr_d    = {parity(wdata_q), wdata_q};
                end else begin
                    to_tail = 1'b1;
                end
            end
            S_WDATA: if (cell_end) begin
                sr_d = {1'b0, sr_q[32:1]};
                if (cnt_q == 6'd32) to_tail = 1'b1;
            end
            S_TAIL: if (cell_end && cnt_q == 6'(IDLE_BITS - 1)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                done    = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (to_tail) begin
            cnt_d   = '0;
            state_d = S_TAIL;
            if (IDLE_BITS == 0) begin
                state_d = S_IDLE;
                done    = 1'b1;
            end
        end
    end

    always_comb begin
        dout_d = 1'b0;
        oe_d   = 1'b1;
        unique case (state_d)
            S_LRST:                 dout_d = 1'b1;
            S_REQ, S_WDATA:         dout_d = sr_d[0];
            S_TRN1, S_ACK,
            S_RDATA, S_TRN2:        oe_d   = 1'b0;
            default:                dout_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLKIN) begin
        if (!nSRSTIN) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            ack_q       <= '0;
            rdok_q      <= 1'b0;
            rnw_q       <= 1'b0;
            wdata_q     <= '0;
            dout_q      <= 1'b0;
            oe_q        <= 1'b1;
            din_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_ack_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_perr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            ack_q       <= ack_d;
            rdok_q      <= rdok_d;
            rsp_valid_q <= done;
            if (accept) begin
                rnw_q   <= bus.req_rnw;
                wdata_q <= bus.req_wdata;
            end
            if (drive_stb) begin
                dout_q <= dout_d;
                oe_q   <= oe_d;
            end
            if (sample_stb) din_q <= SWDIO_i;
            if (done) begin
                rsp_ack_q  <= ack_q;
                rsp_perr_q <= rdok_q & (sr_q[32] ^ parity(sr_q[31:0]));
                if (rdok_q) rsp_rdata_q <= sr_q[31:0];
            end
        end
    end

    assign SWDIO_o       = dout_q;
    assign SWDIO_oe      = oe_q;
    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_ack   = rsp_ack_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_perr  = rsp_perr_q;

endmodule

// File: tb/tb_swd_host.sv
// swd_host bench: target model on the wire, expected responses
// queued by the driver and checked by a response monitor.
module tb_swd_host;
    import swd_host_pkg::*;

    logic CLKIN = 1'b0;
    logic nSRSTIN = 1'b0;
    logic SWDIO_i = 1'b0;
    logic SWCLK, SWDIO_o, SWDIO_oe;

    swd_host_if bus();

    swd_host #(.CLK_DIV(4), .IDLE_BITS(8)) dut (
        .CLKIN    (CLKIN),
        .nSRSTIN  (nSRSTIN),
        .bus      (bus.slave),
        .SWCLK    (SWCLK),
        .SWDIO_o  (SWDIO_o),
        .SWDIO_oe (SWDIO_oe),
        .SWDIO_i  (SWDIO_i)
    );

    always #5 CLKIN = ~CLKIN;

    typedef struct {
        int          id;
        logic [2:0]  ack;
        logic [31:0] rdata;
        logic        perr;
        int          lat;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int nrise = 0;
    logic sclk_prev = 1'b0;
    logic obs_o [64];
    logic obs_oe [64];
    logic [2:0]  tgt_ack = ACK_OK;
    logic [31:0] tgt_data = '0;
    logic        tgt_par = 1'b0;
    logic        tgt_read = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic tgt_bit(input int c);
        if (c >= 9 && c <= 11) return tgt_ack[c-9];
        if (tgt_read && tgt_ack == ACK_OK) begin
            if (c >= 12 && c <= 43) return tgt_data[c-12];
            if (c == 44) return tgt_par;
        end
        return 1'b0;
    endfunction

    always @(posedge CLKIN) cyc <= cyc + 1;

    // target: observes each rising SWCLK, drives the next cell's bit
    always @(negedge CLKIN) begin
        if (bus.req_valid && bus.req_ready) begin
            acc_cyc = cyc + 1;
            nrise = 0;
        end
        if (SWCLK && !sclk_prev) begin
            if (nrise < 64) begin
                obs_o[nrise]  = SWDIO_o;
                obs_oe[nrise] = SWDIO_oe;
            end
            SWDIO_i = tgt_bit(nrise + 1);
            nrise++;
        end
        sclk_prev = SWCLK;
    end

    always @(negedge CLKIN) begin
        if (bus.rsp_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0");
            end else begin
                mon_e = q.pop_front();
                chk($sformatf("t%0d_ack", mon_e.id), 64'(bus.rsp_ack),
                    64'(mon_e.ack));
                chk($sformatf("t%0d_rdata", mon_e.id),
                    64'(bus.rsp_rdata), 64'(mon_e.rdata));
                chk($sformatf("t%0d_perr", mon_e.id), 64'(bus.rsp_perr),
                    64'(mon_e.perr));
                chk($sformatf("t%0d_lat", mon_e.id),
                    64'(cyc - acc_cyc), 64'(mon_e.lat));
            end
        end
    end

    task automatic issue(input logic lrst, input logic apndp,
                         input logic rnw, input logic [1:0] addr,
                         input logic [31:0] wdata);
        @(posedge CLKIN);
        #1;
        bus.req_valid = 1'b1;
        bus.req_lrst  = lrst;
        bus.req_apndp = apndp;
        bus.req_rnw   = rnw;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge CLKIN);
        #1;
        bus.req_valid = 1'b0;
        bus.req_lrst  = 1'b0;
        bus.req_apndp = ~apndp;
        bus.req_rnw   = ~rnw;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wdata;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(posedge CLKIN);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no rsp_valid expected one",
                     name);
            q.delete();
        end
        repeat (3) @(posedge CLKIN);
    endtask

    task automatic push(input int id, input logic [2:0] ack,
                        input logic [31:0] rd, input logic perr,
                        input int lat);
        exp_t e;
        e.id = id; e.ack = ack; e.rdata = rd; e.perr = perr; e.lat = lat;
        q.push_back(e);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_swclk"}, 64'(SWCLK), 64'd0);
        chk({tag, "_dout"}, 64'(SWDIO_o), 64'd0);
        chk({tag, "_oe"}, 64'(SWDIO_oe), 64'd1);
        chk({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
        chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_ack"}, 64'(bus.rsp_ack), 64'd0);
        chk({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'd0);
        chk({tag, "_perr"}, 64'(bus.rsp_perr), 64'd0);
    endtask

    task automatic idcode(input int id);
        logic [7:0] b;
        tgt_ack = ACK_OK; tgt_read = 1'b1;
        tgt_data = 32'h4BA00477; tgt_par = 1'b1;
        push(id, ACK_OK, 32'h4BA00477, 1'b0, 54 * 8);
        issue(1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
        wait_done("idcode");
        for (int i = 0; i < 8; i++) b[i] = obs_o[i];
        chk("idcode_reqbyte", 64'(b), 64'hA5);
        chk("idcode_cells", 64'(nrise), 64'd54);
    endtask

    initial begin
        logic [63:0] m;
        logic [31:0] d;
        int n1, n0;
        bus.req_valid = 1'b0; bus.req_lrst = 1'b0;
        bus.req_apndp = 1'b0; bus.req_rnw = 1'b0;
        bus.req_addr = 2'd0; bus.req_wdata = '0;
        repeat (3) @(posedge CLKIN);
        @(negedge CLKIN);
        chk_reset_vals("rst");
        @(posedge CLKIN);
        #1 nSRSTIN = 1'b1;

        idcode(1);

        // DP ABORT write; WAIT/FAULT not expected here
        tgt_ack = ACK_OK; tgt_read = 1'b0;
        push(2, ACK_OK, 32'h4BA00477, 1'b0, 54 * 8);
        issue(1'b0, 1'b0, 1'b0, 2'd0, 32'h0000001E);
        wait_done("abort");
        m = '0;
        for (int i = 0; i < 54; i++) m[i] = obs_oe[i];
        chk("abort_oe", m, 64'h003F_FFFF_FFFF_E0FF);
        m = '0;
        for (int i = 0; i < 8; i++) m[i] = obs_o[i];
        chk("abort_reqbyte", m, 64'h81);
        for (int i = 0; i < 32; i++) d[i] = obs_o[13+i];
        chk("abort_wdata", 64'(d), 64'h1E);
        chk("abort_wpar", 64'(obs_o[45]), 64'd0);

        // AP read answered WAIT
        tgt_ack = ACK_WAIT; tgt_read = 1'b1;
        tgt_data = 32'hFFFF_FFFF; tgt_par = 1'b1;
        push(3, ACK_WAIT, 32'h4BA00477, 1'b0, 21 * 8);
        issue(1'b0, 1'b1, 1'b1, 2'd3, 32'h0);
        wait_done("wait");
        chk("wait_cells", 64'(nrise), 64'd21);
        n0 = 0;
        for (int i = 13; i < 21; i++)
            if (obs_o[i] == 1'b0 && obs_oe[i] == 1'b1) n0++;
        chk("wait_tail", 64'(n0), 64'd8);

        // FAULT answer, no data phase either
        tgt_ack = ACK_FAULT; tgt_read = 1'b0;
        push(4, ACK_FAULT, 32'h4BA00477, 1'b0, 21 * 8);
        issue(1'b0, 1'b1, 1'b0, 2'd1, 32'h1234_5678);
        wait_done("fault");
        chk("fault_cells", 64'(nrise), 64'd21);

        // bad read parity
        tgt_ack = ACK_OK; tgt_read = 1'b1;
        tgt_data = 32'h4BA00477; tgt_par = 1'b0;
        push(5, ACK_OK, 32'h4BA00477, 1'b1, 54 * 8);
        issue(1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
        wait_done("perr");

        // line reset
        push(6, ACK_OK, 32'h4BA00477, 1'b0, 64 * 8);
        issue(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        wait_done("lrst");
        chk("lrst_cells", 64'(nrise), 64'd64);
        n1 = 0; n0 = 0;
        for (int i = 0; i < 56; i++)
            if (obs_o[i] == 1'b1 && obs_oe[i] == 1'b1) n1++;
        for (int i = 56; i < 64; i++)
            if (obs_o[i] == 1'b0 && obs_oe[i] == 1'b1) n0++;
        chk("lrst_ones", 64'(n1), 64'd56);
        chk("lrst_zeros", 64'(n0), 64'd8);

        // reset during write data bit 10 (cell 23)
        tgt_ack = ACK_OK; tgt_read = 1'b0;
        issue(1'b0, 1'b1, 1'b0, 2'd2, 32'hDEAD_BEEF);
        n1 = 0;
        while (nrise < 24 && n1 < 1000) begin
            @(posedge CLKIN);
            n1++;
        end
        chk("midrst_reached", 64'(nrise >= 24), 64'd1);
        @(posedge CLKIN);
        #1 nSRSTIN = 1'b0;
        @(posedge CLKIN);
        #1 nSRSTIN = 1'b1;
        @(negedge CLKIN);
        chk_reset_vals("midrst");
        repeat (600) @(posedge CLKIN);

        idcode(7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
